// File: rtl/fc_layer.sv
// Dense output layer: loads a feature map, MACs streamed row-major weights, adds biases and
// streams saturated Q-format scores. Define FC_ARGMAX_EN to output only the winning class index.
module fc_layer #(
    parameter int IN_SIZE    = 75,
    parameter int OUT_SIZE   = 10,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_fc,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] map_in_serial,
    input  logic [DATA_WIDTH-1:0] weight_serial,
    input  logic [DATA_WIDTH-1:0] bias_serial,
    output logic                  finish_fc,
    output logic [DATA_WIDTH-1:0] predict_out,
    output logic                  predict_out_valid
);

    localparam int ACC_W = 2 * DATA_WIDTH + $clog2(IN_SIZE) + 1;
    localparam int IW    = $clog2(IN_SIZE + 1);
    localparam int OW    = $clog2(OUT_SIZE + 1);
    localparam logic [IW-1:0] IN_LAST  = IW'(IN_SIZE - 1);
    localparam logic [OW-1:0] OUT_LAST = OW'(OUT_SIZE - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {StIdle, StLoadMap, StMac, StBias, StDone} state_e;

    state_e                         state_q, state_d;
    logic        [DATA_WIDTH-1:0]   map_q [IN_SIZE];
    logic signed [ACC_W-1:0]        sum_q [OUT_SIZE];
    logic signed [ACC_W-1:0]        acc_q, acc_next;
    logic        [IW-1:0]           in_cnt_q;
    logic        [OW-1:0]           out_cnt_q;
    logic                           last_in, last_out;
    logic signed [2*DATA_WIDTH-1:0] product;
    logic signed [ACC_W-1:0]        bias_ext, biased, shifted;
    logic        [DATA_WIDTH-1:0]   score;

    always_comb begin
        last_in  = (in_cnt_q == IN_LAST);
        last_out = (out_cnt_q == OUT_LAST);
        product  = $signed(map_q[in_cnt_q]) * $signed(weight_serial);
        acc_next = acc_q + {{(ACC_W - 2 * DATA_WIDTH){product[2*DATA_WIDTH-1]}}, product};
        bias_ext = {{(ACC_W - DATA_WIDTH){bias_serial[DATA_WIDTH-1]}}, bias_serial};
        // Bias is aligned to the product scale (2*FRAC_BITS) before the floor shift.
        biased   = sum_q[out_cnt_q] + (bias_ext <<< FRAC_BITS);
        shifted  = biased >>> FRAC_BITS;
        if (shifted > SAT_MAX) begin
            score = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            score = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            score = shifted[DATA_WIDTH-1:0];
        end
    end

`ifdef FC_ARGMAX_EN
    logic signed [DATA_WIDTH-1:0] max_q, max_new;
    logic        [OW-1:0]         idx_q, idx_new;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        max_new = max_q;
        idx_new = idx_q;
        if (out_cnt_q == '0 || $signed(score) > max_q) begin
            max_new = $signed(score);
            idx_new = out_cnt_q;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start_fc) state_d = StLoadMap;
            StLoadMap: if (data_valid && last_in) state_d = StMac;
            StMac:     if (data_valid && last_in && last_out) state_d = StBias;
            StBias:    if (data_valid && last_out) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == StLoadMap && data_valid) begin
            map_q[in_cnt_q] <= map_in_serial;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_cnt_q          <= '0;
            out_cnt_q         <= '0;
            acc_q             <= '0;
            finish_fc         <= 1'b0;
            predict_out       <= '0;
            predict_out_valid <= 1'b0;
            for (int j = 0; j < OUT_SIZE; j++) sum_q[j] <= '0;
`ifdef FC_ARGMAX_EN
            max_q             <= '0;
            idx_q             <= '0;
`endif
        end else begin
            finish_fc         <= 1'b0;
            predict_out_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_fc) begin
                        in_cnt_q  <= '0;
                        out_cnt_q <= '0;
                        acc_q     <= '0;
                    end
                end
                StLoadMap: begin
                    if (data_valid) in_cnt_q <= last_in ? '0 : in_cnt_q + 1'b1;
                end
                StMac: begin
                    if (data_valid) begin
                        if (last_in) begin
                            sum_q[out_cnt_q] <= acc_next;
                            acc_q            <= '0;
                            in_cnt_q         <= '0;
                            out_cnt_q        <= last_out ? '0 : out_cnt_q + 1'b1;
                        end else begin
                            acc_q    <= acc_next;
                            in_cnt_q <= in_cnt_q + 1'b1;
                        end
                    end
                end
                StBias: begin
                    if (data_valid) begin
                        out_cnt_q <= last_out ? '0 : out_cnt_q + 1'b1;
`ifdef FC_ARGMAX_EN
                        max_q <= max_new;
                        idx_q <= idx_new;
                        if (last_out) begin
                            predict_out       <= DATA_WIDTH'(idx_new);
                            predict_out_valid <= 1'b1;
                            finish_fc         <= 1'b1;
                        end
`else
                        predict_out       <= score;
                        predict_out_valid <= 1'b1;
                        finish_fc         <= last_out;
`endif
                    end
                end
                StDone: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer.sv
// Directed self-checking bench for fc_layer; score/argmax expectations come from hand tables.
module tb_fc_layer;
    localparam int IN  = 75;
    localparam int OUT = 10;

    logic        clk = 1'b0;
    logic        reset_n, start_fc, data_valid;
    logic [15:0] map_in_serial, weight_serial, bias_serial;
    logic        finish_fc, predict_out_valid;
    logic [15:0] predict_out;

    always #5 clk = ~clk;

    fc_layer #(.IN_SIZE(IN), .OUT_SIZE(OUT), .DATA_WIDTH(16), .FRAC_BITS(8)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start_fc          (start_fc),
        .data_valid        (data_valid),
        .map_in_serial     (map_in_serial),
        .weight_serial     (weight_serial),
        .bias_serial       (bias_serial),
        .finish_fc         (finish_fc),
        .predict_out       (predict_out),
        .predict_out_valid (predict_out_valid)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] got_q[$];
    logic        fin_q[$];
    int          fin_cnt = 0;
    logic [15:0] bias_tab[OUT];
    logic [15:0] exp_tab[OUT];

    always @(negedge clk) begin
        if (predict_out_valid) begin
            got_q.push_back(predict_out);
            fin_q.push_back(finish_fc);
        end
        if (finish_fc) fin_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // phase 2 takes words from bias_tab; optional random gaps and a stray start pulse
    task automatic feed(input int phase, input logic [15:0] word, input int count,
                        input bit gaps, input bit poke);
        for (int n = 0; n < count; n++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    data_valid    = 1'b0;
                    map_in_serial = 16'hDEAD;
                    weight_serial = 16'hDEAD;
                    bias_serial   = 16'hDEAD;
                    tick();
                end
            end
            data_valid    = 1'b1;
            start_fc      = poke && (n == 5);
            map_in_serial = word;
            weight_serial = word;
            bias_serial   = (phase == 2) ? bias_tab[n] : word;
            tick();
        end
        data_valid = 1'b0;
        start_fc   = 1'b0;
    endtask

    task automatic run(input logic [15:0] m, input logic [15:0] w, input bit gaps,
                       input string tag);
        int best;
        got_q.delete();
        fin_q.delete();
        fin_cnt = 0;
        if (gaps) begin
            data_valid    = 1'b1;  // words in IDLE must be dropped
            map_in_serial = 16'h5555;
            repeat (2) tick();
            data_valid = 1'b0;
        end
        start_fc = 1'b1;
        tick();
        if (gaps) tick();
        start_fc = 1'b0;
        feed(0, m, IN, gaps, 1'b0);
        feed(1, w, IN * OUT, gaps, gaps);
        feed(2, 16'h0000, OUT, gaps, 1'b0);
        data_valid = 1'b1;  // surplus words after completion
        repeat (3) tick();
        data_valid = 1'b0;
        repeat (2) tick();
`ifdef FC_ARGMAX_EN
        best = 0;
        for (int o = 1; o < OUT; o++)
            if ($signed(exp_tab[o]) > $signed(exp_tab[best])) best = o;
        chk({tag, "_count"}, got_q.size(), 1);
        chk({tag, "_index"}, (got_q.size() > 0) ? got_q[0] : 16'hxxxx, best);
        chk({tag, "_finflag"}, (fin_q.size() > 0) ? fin_q[0] : 1'bx, 1);
`else
        best = 0;
        chk({tag, "_count"}, got_q.size(), OUT);
        for (int o = 0; o < OUT; o++) begin
            chk($sformatf("%s_score%0d", tag, o),
                (o < got_q.size()) ? got_q[o] : 16'hxxxx, exp_tab[o]);
            chk($sformatf("%s_fin%0d", tag, o),
                (o < fin_q.size()) ? fin_q[o] : 1'bx, (o == OUT - 1));
        end
`endif
        chk({tag, "_finpulses"}, fin_cnt, 1);
    endtask

    task automatic set_tabs(input logic [15:0] score);
        for (int o = 0; o < OUT; o++) begin
            bias_tab[o] = 16'h0000;
            exp_tab[o]  = score;
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        start_fc      = 1'b0;
        data_valid    = 1'b0;
        map_in_serial = '0;
        weight_serial = '0;
        bias_serial   = '0;
        repeat (3) tick();
        chk("reset_valid", predict_out_valid, 0);
        chk("reset_finish", finish_fc, 0);
        chk("reset_predict", predict_out, 0);
        reset_n = 1'b1;
        tick();

        set_tabs(16'h004B);
        run(16'h0100, 16'h0001, 1'b0, "basic");

        set_tabs(16'hFFB5);
        run(16'h0100, 16'hFFFF, 1'b0, "negfloor");

        for (int o = 0; o < OUT; o++) begin
            bias_tab[o] = 16'(o * 256);
            exp_tab[o]  = 16'(o * 256);
        end
        run(16'h0100, 16'h0000, 1'b0, "bias");

        set_tabs(16'h7FFF);
        run(16'h7FFF, 16'h7FFF, 1'b0, "satpos");

        set_tabs(16'h8000);
        run(16'h7FFF, 16'h8000, 1'b0, "satneg");

        set_tabs(16'h004B);
        run(16'h0100, 16'h0001, 1'b1, "stall");

        start_fc = 1'b1;
        tick();
        start_fc = 1'b0;
        feed(0, 16'h0100, IN, 1'b0, 1'b0);
        feed(1, 16'h0003, 200, 1'b0, 1'b0);
        reset_n = 1'b0;
        repeat (2) tick();
        chk("midreset_valid", predict_out_valid, 0);
        chk("midreset_finish", finish_fc, 0);
        chk("midreset_predict", predict_out, 0);
        reset_n = 1'b1;
        tick();
        set_tabs(16'h004B);
        run(16'h0100, 16'h0001, 1'b0, "afterreset");

`ifdef FC_ARGMAX_EN
        bias_tab = '{16'h0100, 16'hFF00, 16'h0300, 16'h0000, 16'h0200,
                     16'h0400, 16'h0100, 16'h0500, 16'h0500, 16'h8000};
        exp_tab  = bias_tab;
        run(16'h0100, 16'h0000, 1'b0, "argmax");
        chk("argmax_is7", (got_q.size() > 0) ? got_q[0] : 16'hxxxx, 16'h0007);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
